// File: rtl/pe_result_drain.sv
// rtl/pe_result_drain.sv - captures final PE result vectors and serialises them lane by lane
module pe_result_drain #(
    parameter int REG_WIDTH = 16,
    parameter int VECTOR    = 6,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic [REG_WIDTH-1:0]         c_in [VECTOR],
    output logic                         full,
    output logic                         overflow,
    input  logic                         clr_ovf,
    output logic [$clog2(DEPTH):0]       vec_count,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [REG_WIDTH-1:0]         out_data,
    output logic [$clog2(VECTOR)-1:0]    out_lane,
    output logic                         out_last
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(VECTOR);
    localparam int CW = PW + 1;

    typedef enum logic {S_EMPTY, S_SEND} state_t;

    state_t               state, state_nxt;
    logic [REG_WIDTH-1:0] mem [DEPTH][VECTOR];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        lane;
    logic                 capture, accept, drop, xfer, lane_end, release_vec;

    // A capture into a full buffer survives only if the head vector leaves on the same edge,
    // because that frees exactly the slot wr_ptr points at.
    assign capture     = in_valid & in_last;
    assign xfer        = out_valid & out_ready;
    assign lane_end    = (lane == LW'(VECTOR - 1));
    assign release_vec = xfer & lane_end;
    assign full        = (vec_count == CW'(DEPTH));
    assign accept      = capture & (~full | release_vec);
    assign drop        = capture & full & ~release_vec;

    assign out_data = out_valid ? mem[rd_ptr][lane] : '0;
    assign out_lane = lane;
    assign out_last = out_valid & lane_end;

    // Result storage: whole vector written unmodified on an accepted capture.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < VECTOR; i++) begin
                mem[wr_ptr][i] <= c_in[i];
            end
        end
    end

    // Pointers, occupancy and serialiser lane position.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lane      <= '0;
            vec_count <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (xfer) begin
                lane <= lane_end ? '0 : lane + 1'b1;
            end
            if (release_vec) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, release_vec})
                2'b10:   vec_count <= vec_count + 1'b1;
                2'b01:   vec_count <= vec_count - 1'b1;
                default: vec_count <= vec_count;
            endcase
        end
    end

    // Sticky drop flag; a drop on the clearing edge keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Serialiser state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Serialiser next state: leave S_SEND only when the last buffered vector drains with no refill.
    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        case (state)
            S_EMPTY: begin
                if (accept) begin
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                out_valid = 1'b1;
                if (release_vec && vec_count == CW'(1) && !accept) begin
                    state_nxt = S_EMPTY;
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

endmodule
